// File: rtl/fc_core_param.sv
// fc_core_param: streaming fixed-point fully-connected layer (x, then W, then bias).
// Define FC_SAT_EN to saturate results to DW bits instead of wrapping.
module fc_core_param #(
   parameter int DW       = 16,
   parameter int FRAC     = 10,
   parameter int CIN_MAX  = 1024,
   parameter int COUT_MAX = 1024,
   parameter int ACC_W    = 40,
   parameter int CW       = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] cin,
   input  logic [CW-1:0] cout,
   input  logic          has_bias,
   input  logic [4:0]    act_type,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic [DW-1:0] din_data,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [DW-1:0] dout_data,
   output logic          busy,
   output logic          done
);

   localparam logic [4:0] ACT_RELU = 5'd1;
   localparam int XA = (CIN_MAX > 1) ? $clog2(CIN_MAX) : 1;
   localparam int OA = (COUT_MAX > 1) ? $clog2(COUT_MAX) : 1;
   localparam logic [CW-1:0] CIN_LIM  = CW'(CIN_MAX);
   localparam logic [CW-1:0] COUT_LIM = CW'(COUT_MAX);
   localparam logic [CW-1:0] ONE      = CW'(1);

   typedef enum logic [2:0] {
      IDLE, READ_INPUT, READ_WEIGHT, READ_BIAS, WRITE_OUTPUT
   } state_t;

   state_t               state;
   logic [CW-1:0]        cin_r, cout_r, i_cnt, o_cnt;
   logic                 bias_r;
   logic [4:0]           act_r;
   logic signed [ACC_W-1:0] acc_run;

   logic signed [DW-1:0]    x_mem   [CIN_MAX];
   logic signed [ACC_W-1:0] acc_mem [COUT_MAX];

   logic                    xfer, last_i, last_o, cfg_ok;
   logic signed [2*DW-1:0]  mul;
   logic signed [ACC_W-1:0] acc_base, acc_next, bias_sum, res;
   logic [DW-1:0]           y;

   assign xfer   = din_valid && din_ready;
   assign last_i = (i_cnt == cin_r - ONE);
   assign last_o = (o_cnt == cout_r - ONE);
   assign cfg_ok = (cin != '0) && (cin <= CIN_LIM)
                && (cout != '0) && (cout <= COUT_LIM);

   assign mul      = x_mem[i_cnt[XA-1:0]] * $signed(din_data);
   assign acc_base = (i_cnt == '0) ? '0 : acc_run;
   assign acc_next = acc_base + ACC_W'(mul);
   // Pre-scaling the bias by FRAC keeps (acc>>>FRAC)+b exact under floor.
   assign bias_sum = acc_mem[o_cnt[OA-1:0]]
                   + (ACC_W'($signed(din_data)) <<< FRAC);

`ifdef FC_SAT_EN
   localparam logic signed [ACC_W-1:0] Y_MAX =
      ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] Y_MIN =
      ACC_W'(-(64'sd1 <<< (DW-1)));

   always_comb begin
      res = acc_mem[o_cnt[OA-1:0]] >>> FRAC;
      if (act_r == ACT_RELU && res[ACC_W-1]) res = '0;
      if (res > Y_MAX)      y = Y_MAX[DW-1:0];
      else if (res < Y_MIN) y = Y_MIN[DW-1:0];
      else                  y = res[DW-1:0];
   end
`else
   logic unused_hi;
   assign unused_hi = ^res[ACC_W-1:DW];

   always_comb begin
      res = acc_mem[o_cnt[OA-1:0]] >>> FRAC;
      if (act_r == ACT_RELU && res[ACC_W-1]) res = '0;
      y = res[DW-1:0];
   end
`endif

   always_ff @(posedge clk) begin
      if (state == READ_INPUT && xfer)
         x_mem[i_cnt[XA-1:0]] <= $signed(din_data);
      if (state == READ_WEIGHT && xfer && last_i)
         acc_mem[o_cnt[OA-1:0]] <= acc_next;
      if (state == READ_BIAS && xfer)
         acc_mem[o_cnt[OA-1:0]] <= bias_sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cin_r      <= '0;
         cout_r     <= '0;
         bias_r     <= 1'b0;
         act_r      <= '0;
         i_cnt      <= '0;
         o_cnt      <= '0;
         acc_run    <= '0;
         din_ready  <= 1'b0;
         dout_valid <= 1'b0;
         dout_data  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && cfg_ok) begin
                  cin_r     <= cin;
                  cout_r    <= cout;
                  bias_r    <= has_bias;
                  act_r     <= act_type;
                  i_cnt     <= '0;
                  o_cnt     <= '0;
                  din_ready <= 1'b1;
                  busy      <= 1'b1;
                  state     <= READ_INPUT;
               end
            end
            READ_INPUT: begin
               if (xfer) begin
                  if (last_i) begin
                     i_cnt <= '0;
                     state <= READ_WEIGHT;
                  end else begin
                     i_cnt <= i_cnt + ONE;
                  end
               end
            end
            READ_WEIGHT: begin
               if (xfer) begin
                  acc_run <= acc_next;
                  if (last_i) begin
                     i_cnt <= '0;
                     if (last_o) begin
                        o_cnt <= '0;
                        if (bias_r) begin
                           state <= READ_BIAS;
                        end else begin
                           din_ready <= 1'b0;
                           state     <= WRITE_OUTPUT;
                        end
                     end else begin
                        o_cnt <= o_cnt + ONE;
                     end
                  end else begin
                     i_cnt <= i_cnt + ONE;
                  end
               end
            end
            READ_BIAS: begin
               if (xfer) begin
                  if (last_o) begin
                     o_cnt     <= '0;
                     din_ready <= 1'b0;
                     state     <= WRITE_OUTPUT;
                  end else begin
                     o_cnt <= o_cnt + ONE;
                  end
               end
            end
            WRITE_OUTPUT: begin
               // Output register refills whenever empty or draining.
               if (!dout_valid || dout_ready) begin
                  if (o_cnt != cout_r) begin
                     dout_data  <= y;
                     dout_valid <= 1'b1;
                     o_cnt      <= o_cnt + ONE;
                  end else if (dout_valid) begin
                     dout_valid <= 1'b0;
                     dout_data  <= '0;
                     o_cnt      <= '0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_core_param.sv
// Randomized scoreboard bench for fc_core_param against an arithmetic model.
// Honors FC_SAT_EN the same way as the design build.
module tb_fc_core_param;

   localparam int DW = 16;
   localparam int FRAC = 10;
   localparam int CW = 11;
   localparam int ACT_RELU = 1;

   logic          clk = 1'b0;
   logic          rst, start, has_bias;
   logic [CW-1:0] cin, cout;
   logic [4:0]    act_type;
   logic          din_valid, din_ready;
   logic [DW-1:0] din_data;
   logic          dout_valid, dout_ready;
   logic [DW-1:0] dout_data;
   logic          busy, done;

   typedef struct {
      logic [DW-1:0] d;
      bit            last;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   int            checks = 0;
   int            fails = 0;
   int            out_cnt = 0;
   int            rmode = 0;
   int            stall_n = 0;
   bit            gaps = 0;
   bit            expect_done = 0;
   bit            stall_pend = 0;
   logic [DW-1:0] held;

   always #5 clk = ~clk;

   fc_core_param dut (
      .clk(clk), .rst(rst), .start(start), .cin(cin), .cout(cout),
      .has_bias(has_bias), .act_type(act_type),
      .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
      .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_data(dout_data), .busy(busy), .done(done)
   );

   task automatic chk(string name, logic [31:0] got, logic [31:0] req);
      checks++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, req);
      end
   endtask

   function automatic void model(int ci, int co, bit hb, int at,
                                 int x[$], int w[$], int b[$]);
      longint acc, r;
      exp_t e;
      for (int o = 0; o < co; o++) begin
         acc = 0;
         for (int i = 0; i < ci; i++)
            acc += longint'(x[i]) * longint'(w[o*ci+i]);
         r = acc >>> FRAC;
         if (hb) r += longint'(b[o]);
         if (at == ACT_RELU && r < 0) r = 0;
`ifdef FC_SAT_EN
         if (r > 32767) r = 32767;
         else if (r < -32768) r = -32768;
`endif
         e.d = r[DW-1:0];
         e.last = (o == co - 1);
         exp_q.push_back(e);
      end
   endfunction

   // Monitor: scoreboard pops, hold-while-stalled and done pulse checks
   always @(negedge clk) begin
      if (expect_done) begin
         chk("done_pulse", done, 1);
         expect_done = 0;
      end else if (done) begin
         chk("done_spurious", done, 0);
      end
      if (stall_pend) begin
         chk("hold_valid", dout_valid, 1);
         chk("hold_data", dout_data, held);
      end
      stall_pend = dout_valid && !dout_ready;
      held = dout_data;
      if (dout_valid && dout_ready) begin
         out_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("dout_data", dout_data, mon_e.d);
            if (mon_e.last) expect_done = 1;
         end
      end
   end

   initial begin
      dout_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_n > 0) begin
            dout_ready = 1'b0;
            stall_n--;
         end else if (rmode == 1) begin
            dout_ready = 1'($urandom_range(1));
         end else begin
            dout_ready = 1'b1;
         end
      end
   end

   task automatic send(input int v);
      int t;
      bit ok;
      t = 0;
      ok = 0;
      if (gaps && $urandom_range(3) == 0) begin
         din_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      din_valid = 1'b1;
      din_data = DW'(v);
      while (!ok) begin
         @(negedge clk);
         if (din_ready) begin
            ok = 1;
         end else if (++t > 100) begin
            chk("din_timeout", 0, 1);
            ok = 1;
         end
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;
   endtask

   task automatic do_start(int ci, int co, bit hb, int at);
      start = 1'b1;
      cin = CW'(ci);
      cout = CW'(co);
      has_bias = hb;
      act_type = 5'(at);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (done !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (done !== 1'b1) chk("done_timeout", 0, 1);
   endtask

   task automatic run_layer(int ci, int co, bit hb, int at,
                            int x[$], int w[$], int b[$], bit stall);
      int base, t;
      base = out_cnt;
      do_start(ci, co, hb, at);
      chk("start_busy", busy, 1);
      model(ci, co, hb, at, x, w, b);
      foreach (x[i]) send(x[i]);
      foreach (w[i]) send(w[i]);
      if (hb) foreach (b[i]) send(b[i]);
      if (stall) begin
         t = 0;
         while (out_cnt <= base && t < 50) begin
            @(posedge clk);
            #1;
            t++;
         end
         stall_n = 3;
      end
      wait_done();
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      int x[$], w[$], b[$];
      int ci, co, at;
      bit hb;
      rst = 1'b1;
      start = 1'b0;
      cin = '0;
      cout = '0;
      has_bias = 1'b0;
      act_type = '0;
      din_valid = 1'b0;
      din_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_din_ready", din_ready, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout_data", dout_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_layer(2, 1, 0, 0, '{1024, 2048}, '{512, 1024}, '{}, 0);
      run_layer(1, 2, 1, ACT_RELU, '{1024}, '{-2048, 3072},
                '{512, -1024}, 0);
      // Back-to-back start lands in the done cycle
      run_layer(1, 2, 1, ACT_RELU, '{1024}, '{-2048, 3072},
                '{512, -1024}, 0);
      run_layer(2, 1, 0, 0, '{32767, 32767}, '{32767, 32767}, '{}, 0);
      run_layer(2, 4, 0, 0, '{1024, 512},
                '{1024, 0, 2048, 0, 3072, 0, 0, 4096}, '{}, 1);

      do_start(0, 1, 0, 0);
      chk("cin0_ignored", busy, 0);
      do_start(1, 2047, 0, 0);
      chk("cout_big_ignored", busy, 0);
      @(posedge clk);
      #1;
      chk("idle_din_ready", din_ready, 0);

      // Reset in the middle of the weight phase
      do_start(2, 1, 0, 0);
      send(1024);
      send(2048);
      send(512);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_din_ready", din_ready, 0);
      chk("mid_rst_dout_valid", dout_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_layer(2, 1, 0, 0, '{1024, 2048}, '{512, 1024}, '{}, 0);

      rmode = 1;
      gaps = 1;
      for (int n = 0; n < 20; n++) begin
         ci = $urandom_range(1, 6);
         co = $urandom_range(1, 5);
         hb = 1'($urandom_range(1));
         at = (n % 3 == 0) ? $urandom_range(0, 31) : (n % 2);
         x.delete();
         w.delete();
         b.delete();
         for (int i = 0; i < ci; i++)
            x.push_back(int'($urandom_range(0, 65535)) - 32768);
         for (int i = 0; i < ci * co; i++)
            w.push_back(int'($urandom_range(0, 65535)) - 32768);
         for (int i = 0; i < co; i++)
            b.push_back(int'($urandom_range(0, 65535)) - 32768);
         run_layer(ci, co, hb, at, x, w, b, 0);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fc_core_param.md
FC_CORE_PARAM -- requirements
Module: fc_core_param

Interface
REQ-001 Parameter DW, default 16: signed data width of inputs, weights, biases and outputs (fixed-point).
REQ-002 Parameter FRAC, default 10: fractional bits of the fixed-point format.
REQ-003 Parameter CIN_MAX, default 1024: maximum input vector length; input buffer depth.
REQ-004 Parameter COUT_MAX, default 1024: maximum output vector length; accumulator/bias buffer depth.
REQ-005 Parameter ACC_W, default 40: signed accumulator width, at least 2*DW.
REQ-006 Parameter CW, default 11: width of cin/cout ports; 2^CW > max(CIN_MAX, COUT_MAX).
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  one-cycle request to begin a layer; sampled only in IDLE.
REQ-010 cin  input  CW  input vector length; latched at accepted start.
REQ-011 cout  input  CW  output vector length; latched at accepted start.
REQ-012 has_bias  input  1  bias phase present; latched at accepted start.
REQ-013 act_type  input  5  activation code from constants.v; latched at accepted start.
REQ-014 din_valid / din_ready  input / output  1 / 1  input stream handshake; transfer when both high.
REQ-015 din_data  input  DW  input, weight or bias word, signed.
REQ-016 dout_valid / dout_ready  output / input  1 / 1  output stream handshake.
REQ-017 dout_data  output  DW  signed result word.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse after final output transfer.

Function
REQ-020 States SHALL be IDLE, READ_INPUT, READ_WEIGHT, READ_BIAS, WRITE_OUTPUT.
REQ-021 IDLE -> READ_INPUT on start with 1<=cin<=CIN_MAX and 1<=cout<=COUT_MAX; any other start is ignored.
REQ-022 din_ready SHALL be high exactly in READ_INPUT, READ_WEIGHT, READ_BIAS.
REQ-023 READ_INPUT stores cin words in order x[0..cin-1], then -> READ_WEIGHT.
REQ-024 READ_WEIGHT accepts cin*cout weights output-major: w[o][i], i fastest; each accepted weight does acc[o] += x[i]*w[o][i] in full ACC_W precision, acc[o] starting from 0 at i=0.
REQ-025 After the last weight: -> READ_BIAS if has_bias, else -> WRITE_OUTPUT.
REQ-026 READ_BIAS accepts cout words b[0..cout-1], then -> WRITE_OUTPUT; without has_bias, b[o]=0.
REQ-027 Result y[o] = act((acc[o] >>> FRAC) + b[o]), arithmetic shift, truncation toward minus infinity.
REQ-028 act: ACT_RELU maps negative to 0; every other code is identity.
REQ-029 Narrowing to DW per REQ-038/039.
REQ-030 WRITE_OUTPUT emits y[0..cout-1] in order; first dout_valid no later than 2 cycles after the final weight/bias transfer.
REQ-031 While dout_valid && !dout_ready, dout_data SHALL hold stable; dout_valid never drops before transfer.
REQ-032 With dout_ready held high, one output per cycle, no bubbles.
REQ-033 Final output transfer -> IDLE; done pulses the following cycle; a new start is accepted in that cycle.
REQ-034 start while busy is ignored; din words while din_ready low are not consumed.

Reset
REQ-035 rst SHALL immediately force IDLE, cnt/addresses 0, and busy, done, din_ready, dout_valid to 0, dout_data to 0, regardless of state.
REQ-036 Reset mid-layer discards all buffered data; the next accepted start behaves as after power-up.
REQ-037 Buffer contents need not be reset; no stale value SHALL reach dout_data.

Configuration
REQ-038 With FC_SAT_EN defined, the result SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-039 Without FC_SAT_EN, the result SHALL be the low DW bits (two's-complement wrap).

Verification
REQ-040 cin=2, cout=1, x={1024,2048}, w={512,1024}, no bias, ACT_NONE -> single dout_data=2560, then done pulse.
REQ-041 cin=1, cout=2, x={1024}, w={-2048,3072}, b={512,-1024}, ACT_RELU -> dout_data 0, then 2048.
REQ-042 cin=2, cout=1, x={32767,32767}, w={32767,32767}, no bias -> 32767 with FC_SAT_EN; -128 without.
REQ-043 cout=4, dout_ready low 3 cycles mid-stream -> dout_data stable while stalled, all 4 outputs in order, none duplicated.
REQ-044 rst asserted during READ_WEIGHT -> busy, din_ready, dout_valid 0 same cycle; rerun of REQ-040 yields 2560.
REQ-045 Start issued the cycle done pulses, rerun of REQ-041 -> accepted, identical outputs; start with cin=0 -> ignored, busy stays 0.
